// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared types and constants for the data-memory preload loader.
//   state_t    - loader FSM states
//   mem_wr_t   - one preload write (byte address + word)
//   word_fits  - address range check done one bit wider than the address
package mem_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HDR_W          = HDR_BYTES * BYTE_W;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } mem_wr_t;

  // True when a full word at addr lies inside [0, limit); the extra bit
  // makes an address that wraps past 2^32 count as out of range.
  function automatic logic word_fits(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W:0]   limit);
    logic [ADDR_W:0] word_end;
    word_end = {1'b0, addr} + (ADDR_W+1)'(BYTES_PER_WORD);
    return (word_end <= limit);
  endfunction

endpackage

// File: rtl/mem_loader_byte_packer.sv
// mem_loader_byte_packer: collects stream bytes into big-endian 32-bit words.
//   clk, rst_n    - clock, async active-low reset
//   clear         - synchronous discard of any partially packed word
//   push, byte_in - one byte accepted this cycle
//   word_valid_c  - combinational: this push completes a word
//   word_c        - combinational: the completed word (first byte in [31:24])
module mem_loader_byte_packer
  import mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_valid_c,
  output logic [WORD_W-1:0] word_c
);

  // Only the first three bytes need storage; the fourth arrives on byte_in.
  logic [WORD_W-BYTE_W-1:0] shift_q;
  logic [IDX_W-1:0]         idx_q;

  // Shift register and byte index; index wraps naturally after the 4th byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (push) begin
      shift_q <= {shift_q[WORD_W-2*BYTE_W-1:0], byte_in};
      idx_q   <= idx_q + IDX_W'(1);
    end
  end

  assign word_valid_c = push && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
  assign word_c       = {shift_q, byte_in};

endmodule

// File: rtl/mem_loader.sv
// mem_loader: drives the data memory preload port from a byte stream.
// Stream: 2-byte big-endian word count N, then 4N bytes packed big-endian.
//   clk, rst_n          - clock, async active-low reset
//   start               - arms a new load (honoured in IDLE or DONE)
//   in_valid, in_data   - byte stream in; in_ready - byte accepted this cycle
//   ext_data            - word to write
//   ext_data_addr       - word-aligned byte address of ext_data
//   ext_data_en         - one-cycle write strobe
//   cpu_hold            - core stall while a load is armed or running
//   done                - load finished, held until next start
//   err                 - sticky: a word fell outside MEM_BYTES
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic [WORD_W-1:0] ext_data,
  output logic [ADDR_W-1:0] ext_data_addr,
  output logic              ext_data_en,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_t             state_q, state_d;
  logic               armed_q;
  logic [BYTE_W-1:0]  hdr_hi_q, hdr_hi_d;
  logic [CNT_W-1:0]   words_left_q, words_left_d;
  logic               adv_q, adv_d;
  mem_wr_t            wr_q, wr_d;
  logic               wr_en_d;
  logic               in_ready_d, cpu_hold_d, done_d, err_d;

  logic               xfer_c;
  logic               start_ok_c;
  logic               push_c;
  logic               word_valid_c;
  logic [WORD_W-1:0]  word_c;
  logic [HDR_W-1:0]   hdr_full_c;
  logic [CNT_W-1:0]   hdr_count_c;
  logic               loading_c;

  assign xfer_c      = in_valid && in_ready;
  // armed_q keeps a start coincident with reset release from being taken.
  assign start_ok_c  = start && armed_q && ((state_q == IDLE) || (state_q == DONE));
  assign push_c      = xfer_c && (state_q == DATA);
  assign hdr_full_c  = {hdr_hi_q, in_data};
  assign hdr_count_c = CNT_W'(hdr_full_c);

  mem_loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (start_ok_c),
    .push         (push_c),
    .byte_in      (in_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      hdr_hi_q     <= '0;
      words_left_q <= '0;
      adv_q        <= 1'b0;
      wr_q         <= '{addr: BASE_ADDR, data: '0};
      ext_data_en  <= 1'b0;
      in_ready     <= 1'b0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= 1'b1;
      hdr_hi_q     <= hdr_hi_d;
      words_left_q <= words_left_d;
      adv_q        <= adv_d;
      wr_q         <= wr_d;
      ext_data_en  <= wr_en_d;
      in_ready     <= in_ready_d;
      cpu_hold     <= cpu_hold_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok_c) state_d = HDR_HI;
      HDR_HI:  if (xfer_c) state_d = HDR_LO;
      HDR_LO:  if (xfer_c) state_d = (hdr_count_c == '0) ? DONE : DATA;
      DATA:    if (word_valid_c && (words_left_q == CNT_W'(1))) state_d = DONE;
      DONE:    if (start_ok_c) state_d = HDR_HI;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, counters and write payload.
  always_comb begin
    loading_c    = (state_d == HDR_HI) || (state_d == HDR_LO) || (state_d == DATA);
    in_ready_d   = loading_c;
    cpu_hold_d   = loading_c;
    done_d       = (state_d == DONE);
    err_d        = err;
    wr_en_d      = 1'b0;
    wr_d         = wr_q;
    hdr_hi_d     = hdr_hi_q;
    words_left_d = words_left_q;
    adv_d        = 1'b0;

    // Address steps on the edge after each word, written or suppressed.
    if (adv_q) wr_d.addr = wr_q.addr + ADDR_W'(BYTES_PER_WORD);

    if (start_ok_c) begin
      err_d     = 1'b0;
      wr_d.addr = BASE_ADDR;
    end

    if ((state_q == HDR_HI) && xfer_c) hdr_hi_d = in_data;
    if ((state_q == HDR_LO) && xfer_c) words_left_d = hdr_count_c;

    if (word_valid_c) begin
      words_left_d = words_left_q - CNT_W'(1);
      adv_d        = 1'b1;
      wr_d.data    = word_c;
      // Out-of-range words are still consumed to keep the stream framed.
      if (word_fits(wr_q.addr, MEM_LIMIT)) wr_en_d = 1'b1;
      else                                 err_d   = 1'b1;
    end
  end

  assign ext_data      = wr_q.data;
  assign ext_data_addr = wr_q.addr;

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Initiator side of the data memory's external preload port.
- Accepts a byte stream over a valid/ready handshake, normally from a UART or test host.
- Packs bytes big-endian into 32-bit words and drives ext_data / ext_data_addr / ext_data_en to fill data memory before the core runs.
- Holds the core in stall until the image is loaded.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first word written.
- MEM_BYTES, 256: data memory size in bytes; bounds the address range.
- CNT_W, 16: width of the word-count header field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; arms a new load (accepted in IDLE or DONE only).
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts in_data this cycle.
- ext_data  output  32  word to write, big-endian packed.
- ext_data_addr  output  32  byte address of the word, word aligned.
- ext_data_en  output  1  one-cycle write strobe to data memory.
- cpu_hold  output  1  high while a load is armed or in progress.
- done  output  1  high from load completion until the next start.
- err  output  1  sticky overflow flag; cleared by start.

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready=0, ext_data_en=0, ext_data=0, ext_data_addr=BASE_ADDR, cpu_hold=0, done=0, err=0, byte index=0, word count=0.
- All outputs are registered. Clear ext_data_en combinationally from the state on reset so no partial write can occur.
- Stream format:
  - Bytes 0-1: word count N, big-endian, CNT_W bits.
  - Then 4N data bytes. Within each word, the first byte becomes ext_data[31:24] and the last becomes [7:0].
- A byte is transferred on a rising edge where in_valid && in_ready.
- States:
  - IDLE: in_ready=0. On start -> HDR_HI; cpu_hold=1, done=0, err=0, addr=BASE_ADDR.
  - HDR_HI: in_ready=1. On transfer, latch N[15:8] -> HDR_LO.
  - HDR_LO: in_ready=1. On transfer, latch N[7:0]. If full N==0 -> DONE, else -> DATA.
  - DATA: in_ready=1. On each transfer, shift the byte into the pack register and increment the byte index (0..3).
    - When the 4th byte transfers at edge k: ext_data and ext_data_addr are valid and ext_data_en=1 for exactly the cycle after edge k.
    - ext_data_addr advances by 4 on the edge following the strobe.
    - The remaining-word count decrements.
    - No back-pressure is needed: in_ready stays 1, and byte 0 of the next word can transfer on the same edge the strobe is issued.
    - After the last word's strobe -> DONE.
  - DONE: in_ready=0, cpu_hold=0, done=1. Further in_valid is ignored. start -> HDR_HI as from IDLE.
- Overflow:
  - If a word's address + 4 > MEM_BYTES, suppress that strobe (ext_data_en stays 0) and set err=1.
  - Consumption continues so the stream stays framed.
  - done is still reached after N words.
- start asserted mid-load (HDR_HI..DATA): ignored.
- start in the same cycle as reset deassertion: ignored. The state machine begins only on the first edge with rst_n high.
- Reset mid-load: immediate abort to IDLE and cpu_hold drops. Partially packed bytes are discarded and no strobe is issued.
- Address width: the increment wraps mod 2^32. The overflow check is done in 33 bits so a wrap is caught as overflow.
- ext_data holds its last value between strobes; memory samples it only when ext_data_en=1.

Decomposition:
- Shared package holds:
  - State enum: IDLE, HDR_HI, HDR_LO, DATA, DONE.
  - Header byte count constant: 2.
  - Bytes-per-word constant: 4.
- One natural sub-module: byte_packer.
  - Shift register plus 2-bit index.
  - Outputs word_valid pulse and packed word.
  - Cleared by rst_n or a clear input.
- The FSM, counters and address logic stay in mem_loader.

Test Plan:
- N=2, stream 00 02 DE AD BE EF 01 23 45 67, in_valid held high, BASE_ADDR=0 -> two single-cycle strobes: DEADBEEF @0x00, then 01234567 @0x04; done=1 after second strobe; cpu_hold falls the same cycle done rises; err=0.
- Same stream with in_valid toggled every other cycle -> identical writes and addresses; each strobe occurs exactly one cycle after the 4th byte of its word transfers.
- N=0 (00 00) -> no strobes; DONE reached one cycle after the second header byte; in_ready=0 thereafter.
- MEM_BYTES=8, N=3, words 11111111 22222222 33333333 -> writes @0x00 and @0x04 only; third strobe suppressed; err=1; done=1.
- rst_n pulsed low after 6 bytes of an N=2 load -> all outputs return to reset values asynchronously with no strobe; a new start with a full stream loads correctly from BASE_ADDR.
- start during DATA, then a second load after DONE -> first start has no effect; second load clears err and done and rewrites from BASE_ADDR.
